vend_dispense_sched: RTL
========================

// Module: vend_dispense_sched
// PURPOSE
//  Scheduler that shares one tea/coffee dispense mechanism between N customer front panels.
//  - Arbitrates orders round-robin.
//  - Tracks tea and coffee stock; rejects orders for items that are out of stock.
//  - Sequences the dispenser with a start/done handshake and watchdogs it against a hung mechanism.
//  Sits between the panel coin/credit logic (upstream) and the dispenser (downstream).
// PARAMETERS
//  N_PANELS      2    number of requesting panels (2..4)
//  STOCK_W       2    width of each stock counter; also width of the load values
//  DISP_TIMEOUT  15   max cycles in BUSY without disp_done before FAULT (>=2)
//  IDX_W         localparam = $clog2(N_PANELS), min 1
// PORTS
//  clk               in   1         rising-edge clock
//  rst               in   1         synchronous reset, active-low
//  ord_valid         in   N_PANELS  per-panel order request; held until ord_ready or ord_reject
//  ord_item          in   N_PANELS  per-panel item select: 0 = tea, 1 = coffee; stable while valid
//  ord_ready         out  N_PANELS  one-hot, 1-cycle pulse: order accepted
//  ord_reject        out  N_PANELS  one-hot, 1-cycle pulse: item out of stock
//  refill            in   1         load stock counters from *_loaded
//  tea_loaded        in   STOCK_W   tea stock value to load
//  coffee_loaded     in   STOCK_W   coffee stock value to load
//  disp_start        out  1         1-cycle pulse: begin dispensing
//  disp_item         out  1         item being dispensed; held from disp_start until the return to IDLE
//  disp_panel        out  IDX_W     panel being served; held like disp_item
//  disp_done         in   1         dispenser completion pulse
//  fault             out  1         dispenser timeout flag; level, held until cleared
//  fault_clr         in   1         clears FAULT
//  tea_available     out  STOCK_W   current tea stock
//  coffee_available  out  STOCK_W   current coffee stock
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//   - state IDLE; both stock counters 0; round-robin pointer 0; busy counter 0.
//   - All outputs 0.
//   - Reset wins over every other input in every state, including mid-dispense; no done is awaited.
//  States: IDLE, CHECK, BUSY, FAULT. All outputs are registered.
//  IDLE:
//   - refill=1: counters <= tea_loaded/coffee_loaded (replace, not add); no grant this edge.
//   - else if any ord_valid: winner = first valid panel at or after the pointer (wrapping).
//     Capture winner index and its ord_item; -> CHECK.
//   - disp_done in IDLE is ignored.
//  CHECK (one cycle):
//   - Captured item stock == 0: ord_reject[w] pulses for 1 cycle; -> IDLE.
//   - Else, in the same cycle: ord_ready[w] and disp_start pulse for 1 cycle;
//     disp_item/disp_panel driven; that stock counter decrements by 1; busy counter cleared; -> BUSY.
//   - Pointer <= (w+1) mod N_PANELS on both reject and accept.
//  Latency: valid sampled at edge E0 in IDLE -> ready/reject/disp_start high in the cycle after E0+1.
//  BUSY:
//   - Busy counter increments each cycle.
//   - disp_done=1 -> IDLE.
//   - Counter reaches DISP_TIMEOUT with no done -> FAULT.
//   - disp_done on the timeout cycle: done wins, -> IDLE.
//   - refill and orders are ignored; requesters stay pending.
//  FAULT:
//   - fault=1; stock is not restored (the decrement stands); orders and refill are ignored.
//   - fault_clr=1 -> IDLE, fault <= 0.
//  General:
//   - Refill is accepted only in IDLE.
//   - Back-to-back orders are legal: IDLE -> CHECK directly after the return from BUSY.
//   - Stock never underflows: decrement only on nonzero, enforced by CHECK.
// STRUCTURE
//  - vend_pkg: ITEM_TEA=1'b0, ITEM_COFFEE=1'b1; state encoding (IDLE/CHECK/BUSY/FAULT).
//  - Sub-module vend_rr_arb: N-way round-robin arbiter.
//    Inputs: req vector, pointer. Output: one-hot grant plus index. Combinational.
//  - Top level holds the FSM, stock counters, watchdog counter and output registers.
// TESTING
//  1. Reset, refill tea=2 coffee=2; panel0 orders tea, done after 3 cycles.
//     -> ord_ready[0], disp_start, disp_item=0, tea_available=1.
//  2. Panel0 and panel1 both hold valid (pointer=0).
//     -> panel0 served first, then panel1 without re-request; ord_ready order 0,1.
//  3. Coffee stock 0, panel1 orders coffee.
//     -> ord_reject[1] one cycle; no disp_start; coffee_available stays 0.
//  4. disp_done withheld for DISP_TIMEOUT cycles.
//     -> fault=1; new orders ignored; fault_clr -> IDLE; next order served.
//  5. rst=0 while in BUSY.
//     -> all outputs 0 and stock 0 the next cycle; a late disp_done is ignored.
//  6. refill pulsed in BUSY.
//     -> no stock change; refill in IDLE with tea_loaded=3 -> tea_available=3.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the tea/coffee dispense scheduler: item codes,
// FSM state encoding and the panel-index width helper.
package vend_pkg;

    localparam logic ITEM_TEA    = 1'b0;
    localparam logic ITEM_COFFEE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_BUSY  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Panel index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_dispense_sched_if.sv
// Order handshake from the panels and the start/done handshake to the
// dispenser, bundled for the scheduler port list.
interface vend_dispense_sched_if #(
    parameter int N_PANELS = 2
);
    localparam int IDX_W = vend_pkg::idx_w(N_PANELS);

    // Handshake rules: a panel raises ord_valid[i] with a stable ord_item[i]
    // and holds both until exactly one of ord_ready[i] / ord_reject[i] pulses
    // for one cycle. disp_start pulses once per accepted order; disp_item and
    // disp_panel stay valid until the scheduler returns to idle. disp_done is a
    // one-cycle completion pulse that only counts while a dispense is running.
    logic [N_PANELS-1:0] ord_valid;
    logic [N_PANELS-1:0] ord_item;
    logic [N_PANELS-1:0] ord_ready;
    logic [N_PANELS-1:0] ord_reject;
    logic                disp_start;
    logic                disp_item;
    logic [IDX_W-1:0]    disp_panel;
    logic                disp_done;

    modport master (
        output ord_valid, ord_item, disp_done,
        input  ord_ready, ord_reject, disp_start, disp_item, disp_panel
    );

    modport slave (
        input  ord_valid, ord_item, disp_done,
        output ord_ready, ord_reject, disp_start, disp_item, disp_panel
    );

endinterface

// File: rtl/vend_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around the panel count.
module vend_rr_arb #(
    parameter int N_PANELS = 2,
    parameter int IDX_W    = 1
) (
    input  logic [N_PANELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [N_PANELS-1:0] gnt,
    output logic [IDX_W-1:0]    gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_PANELS; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_PANELS);
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

endmodule

// File: rtl/vend_dispense_sched.sv
// Shares one dispense mechanism between several panels: round-robin order
// arbitration, stock tracking with out-of-stock rejection, and a watchdog.
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int N_PANELS     = 2,
    parameter int STOCK_W      = 2,
    parameter int DISP_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    vend_dispense_sched_if.slave   bus,
    input  logic                   refill,
    input  logic [STOCK_W-1:0]     tea_loaded,
    input  logic [STOCK_W-1:0]     coffee_loaded,
    input  logic                   fault_clr,
    output logic                   fault,
    output logic [STOCK_W-1:0]     tea_available,
    output logic [STOCK_W-1:0]     coffee_available,
    output state_t                 dbg_state
);

    localparam int IDX_W = idx_w(N_PANELS);
    localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [STOCK_W-1:0]  tea_q, tea_d, coffee_q, coffee_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    win_idx_q, win_idx_d;
    logic                win_item_q, win_item_d;
    logic [N_PANELS-1:0] ready_d, reject_d;
    logic                start_d;
    logic                disp_item_q, disp_item_d;
    logic [IDX_W-1:0]    disp_panel_q, disp_panel_d;
    logic                fault_q, fault_d;

    logic [N_PANELS-1:0] gnt;
    logic [IDX_W-1:0]    gnt_idx;
    logic [STOCK_W-1:0]  sel_stock;
    logic [CNT_W-1:0]    cnt_inc;
    logic [IDX_W-1:0]    ptr_next;

    vend_rr_arb #(
        .N_PANELS (N_PANELS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .req     (bus.ord_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_stock = (win_item_q == ITEM_COFFEE) ? coffee_q : tea_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign ptr_next  = (win_idx_q == IDX_W'(N_PANELS - 1)) ? '0 : win_idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        tea_d        = tea_q;
        coffee_d     = coffee_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        win_idx_d    = win_idx_q;
        win_item_d   = win_item_q;
        ready_d      = '0;
        reject_d     = '0;
        start_d      = 1'b0;
        disp_item_d  = disp_item_q;
        disp_panel_d = disp_panel_q;
        fault_d      = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (refill) begin
                    tea_d    = tea_loaded;
                    coffee_d = coffee_loaded;
                end else if (|bus.ord_valid) begin
                    win_idx_d  = gnt_idx;
                    win_item_d = |(gnt & bus.ord_item);
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ptr_d = ptr_next;
                if (sel_stock == '0) begin
                    reject_d[win_idx_q] = 1'b1;
                    state_d             = ST_IDLE;
                end else begin
                    ready_d[win_idx_q] = 1'b1;
                    start_d            = 1'b1;
                    disp_item_d        = win_item_q;
                    disp_panel_d       = win_idx_q;
                    cnt_d              = '0;
                    state_d            = ST_BUSY;
                    if (win_item_q == ITEM_COFFEE) coffee_d = coffee_q - STOCK_W'(1);
                    else                           tea_d    = tea_q - STOCK_W'(1);
                end
            end
            ST_BUSY: begin
                // Completion beats the watchdog when both land on the same cycle.
                if (bus.disp_done) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    disp_item_d  = 1'b0;
                    disp_panel_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(DISP_TIMEOUT)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d      = ST_IDLE;
                    fault_d      = 1'b0;
                    cnt_d        = '0;
                    disp_item_d  = 1'b0;
                    disp_panel_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tea_q          <= '0;
            coffee_q       <= '0;
            ptr_q          <= '0;
            cnt_q          <= '0;
            win_idx_q      <= '0;
            win_item_q     <= 1'b0;
            bus.ord_ready  <= '0;
            bus.ord_reject <= '0;
            bus.disp_start <= 1'b0;
            disp_item_q    <= 1'b0;
            disp_panel_q   <= '0;
            fault_q        <= 1'b0;
        end else begin
            tea_q          <= tea_d;
            coffee_q       <= coffee_d;
            ptr_q          <= ptr_d;
            cnt_q          <= cnt_d;
            win_idx_q      <= win_idx_d;
            win_item_q     <= win_item_d;
            bus.ord_ready  <= ready_d;
            bus.ord_reject <= reject_d;
            bus.disp_start <= start_d;
            disp_item_q    <= disp_item_d;
            disp_panel_q   <= disp_panel_d;
            fault_q        <= fault_d;
        end
    end

    assign bus.disp_item    = disp_item_q;
    assign bus.disp_panel   = disp_panel_q;
    assign fault            = fault_q;
    assign tea_available    = tea_q;
    assign coffee_available = coffee_q;
    assign dbg_state        = state_q;

endmodule
